// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve/play/miss/game-over flow, lives and score counters.
// Optional pause support is compiled in when PONG_PAUSE_EN is defined.
module pong_game_ctrl #(
    parameter int unsigned LIVES_INIT   = 3,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned MISS_FRAMES  = 90,
    parameter int unsigned SCORE_W      = 8
) (
    input  logic               Clk_100MHz,
    input  logic               Reset,
    input  logic               Start,
`ifdef PONG_PAUSE_EN
    input  logic               Pause,
`endif
    input  logic               FrameTick,
    input  logic [2:0]         ColOut,
    output logic               GameEnable,
    output logic               ballPosReset,
    output logic               LivesCountReset,
    output logic [1:0]         LivesCount,
    output logic [SCORE_W-1:0] Score,
    output logic [2:0]         GameState
);

    localparam int unsigned MAX_FRAMES = (SERVE_FRAMES > MISS_FRAMES) ? SERVE_FRAMES : MISS_FRAMES;
    localparam int unsigned CNT_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        SERVE = 3'b001,
        PLAY  = 3'b010,
        MISS  = 3'b011,
        OVER  = 3'b100
`ifdef PONG_PAUSE_EN
        ,
        PAUSE = 3'b101
`endif
    } stateType;

    stateType           state, stateNext;
    logic [CNT_W-1:0]   frameCnt, cntNext;
    logic [1:0]         livesNext;
    logic [SCORE_W-1:0] scoreNext;
    logic               bprNext, lcrNext;

    logic startS1, startS2, startS3, startP;
    logic [2:0] colQ;
    logic hitP, missP;

`ifdef PONG_PAUSE_EN
    logic pauseS1, pauseS2, pauseS3, pauseP;

    always_ff @(posedge Clk_100MHz or negedge Reset) begin
        if (!Reset) begin
            pauseS1 <= 1'b0;
            pauseS2 <= 1'b0;
            pauseS3 <= 1'b0;
        end else begin
            pauseS1 <= Pause;
            pauseS2 <= pauseS1;
            pauseS3 <= pauseS2;
        end
    end

    assign pauseP = pauseS2 & ~pauseS3;
`endif

    always_ff @(posedge Clk_100MHz or negedge Reset) begin
        if (!Reset) begin
            startS1 <= 1'b0;
            startS2 <= 1'b0;
            startS3 <= 1'b0;
            colQ    <= '0;
        end else begin
            startS1 <= Start;
            startS2 <= startS1;
            startS3 <= startS2;
            colQ    <= ColOut;
        end
    end

    // Edge detects: a held button or sustained collision code counts once
    assign startP = startS2 & ~startS3;
    assign hitP   = (ColOut == 3'b100) && (colQ != 3'b100);
    assign missP  = (ColOut == 3'b101) && (colQ != 3'b101);

    always_comb begin
        stateNext = state;
        cntNext   = frameCnt;
        livesNext = LivesCount;
        scoreNext = Score;
        bprNext   = 1'b0;
        lcrNext   = 1'b0;
        case (state)
            IDLE, OVER: begin
                if (startP) begin
                    livesNext = 2'(LIVES_INIT);
                    scoreNext = '0;
                    bprNext   = 1'b1;
                    lcrNext   = 1'b1;
                    stateNext = SERVE;
                end
            end
            SERVE: begin
                if (FrameTick) begin
                    if (frameCnt == CNT_W'(SERVE_FRAMES - 1)) stateNext = PLAY;
                    else                                      cntNext   = frameCnt + 1'b1;
                end
            end
            PLAY: begin
`ifdef PONG_PAUSE_EN
                if (pauseP) stateNext = PAUSE;
                else
`endif
                if (missP) begin
                    if (LivesCount > 2'd1) begin
                        livesNext = LivesCount - 2'd1;
                        stateNext = MISS;
                    end else begin
                        livesNext = 2'd0;
                        stateNext = OVER;
                    end
                end else if (hitP && (Score != '1)) begin
                    scoreNext = Score + 1'b1;
                end
            end
            MISS: begin
                if (FrameTick) begin
                    if (frameCnt == CNT_W'(MISS_FRAMES - 1)) begin
                        stateNext = SERVE;
                        bprNext   = 1'b1;
                    end else begin
                        cntNext = frameCnt + 1'b1;
                    end
                end
            end
`ifdef PONG_PAUSE_EN
            PAUSE: begin
                if (pauseP) stateNext = PLAY;
            end
`endif
            default: stateNext = IDLE;
        endcase
        if (stateNext != state) cntNext = '0;
    end

    always_ff @(posedge Clk_100MHz or negedge Reset) begin
        if (!Reset) begin
            state           <= IDLE;
            frameCnt        <= '0;
            LivesCount      <= 2'(LIVES_INIT);
            Score           <= '0;
            ballPosReset    <= 1'b0;
            LivesCountReset <= 1'b0;
            GameEnable      <= 1'b0;
        end else begin
            state           <= stateNext;
            frameCnt        <= cntNext;
            LivesCount      <= livesNext;
            Score           <= scoreNext;
            ballPosReset    <= bprNext;
            LivesCountReset <= lcrNext;
            GameEnable      <= (stateNext == PLAY);
        end
    end

    assign GameState = state;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed self-checking bench for pong_game_ctrl (pause path exercised when PONG_PAUSE_EN is defined).
module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       rstN;
    logic       start;
    logic       frameTick;
    logic [2:0] colOut;
    logic       gameEnable, bpr, lcr;
    logic [1:0] lives;
    logic [7:0] score;
    logic [2:0] gameState;
`ifdef PONG_PAUSE_EN
    logic       pause;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pong_game_ctrl #(
        .LIVES_INIT  (3),
        .SERVE_FRAMES(60),
        .MISS_FRAMES (90),
        .SCORE_W     (8)
    ) dut (
        .Clk_100MHz     (clk),
        .Reset          (rstN),
        .Start          (start),
`ifdef PONG_PAUSE_EN
        .Pause          (pause),
`endif
        .FrameTick      (frameTick),
        .ColOut         (colOut),
        .GameEnable     (gameEnable),
        .ballPosReset   (bpr),
        .LivesCountReset(lcr),
        .LivesCount     (lives),
        .Score          (score),
        .GameState      (gameState)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frameTick = 1'b1;
            step(1);
            frameTick = 1'b0;
            step(1);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkStatus(input string tag, input logic [2:0] st, input logic en,
                               input logic [1:0] lv, input logic [7:0] sc);
        check({tag, ".state"}, 32'(gameState), 32'(st));
        check({tag, ".enable"}, 32'(gameEnable), 32'(en));
        check({tag, ".lives"}, 32'(lives), 32'(lv));
        check({tag, ".score"}, 32'(score), 32'(sc));
    endtask

    task automatic checkPulses(input string tag, input logic expBpr, input logic expLcr);
        check({tag, ".ballPosReset"}, 32'(bpr), 32'(expBpr));
        check({tag, ".livesCountReset"}, 32'(lcr), 32'(expLcr));
    endtask

    // Raise Start and verify the new-game pulses land on the third clock
    task automatic startGame(input string tag, input logic [2:0] fromState);
        start = 1'b1;
        step(2);
        check({tag, ".preState"}, 32'(gameState), 32'(fromState));
        checkPulses({tag, ".pre"}, 1'b0, 1'b0);
        step(1);
        checkPulses({tag, ".pulse"}, 1'b1, 1'b1);
        checkStatus({tag, ".serve"}, 3'b001, 1'b0, 2'd3, 8'd0);
        start = 1'b0;
        step(1);
        checkPulses({tag, ".post"}, 1'b0, 1'b0);
    endtask

    task automatic serveToPlay(input string tag, input logic [1:0] lv, input logic [7:0] sc);
        frames(59);
        checkStatus({tag, ".serve59"}, 3'b001, 1'b0, lv, sc);
        frames(1);
        checkStatus({tag, ".play"}, 3'b010, 1'b1, lv, sc);
    endtask

    task automatic missToServe(input string tag, input logic [1:0] lv, input logic [7:0] sc);
        frames(89);
        checkStatus({tag, ".miss89"}, 3'b011, 1'b0, lv, sc);
        check({tag, ".noPulse"}, 32'(bpr), 32'd0);
        frameTick = 1'b1;
        step(1);
        frameTick = 1'b0;
        checkPulses({tag, ".reserve"}, 1'b1, 1'b0);
        check({tag, ".serveState"}, 32'(gameState), 32'd1);
        step(1);
        checkPulses({tag, ".reservePost"}, 1'b0, 1'b0);
    endtask

    initial begin
        rstN      = 1'b0;
        start     = 1'b0;
        frameTick = 1'b0;
        colOut    = 3'b000;
`ifdef PONG_PAUSE_EN
        pause     = 1'b0;
`endif
        step(5);
        checkStatus("inReset", 3'b000, 1'b0, 2'd3, 8'd0);
        rstN = 1'b1;
        step(1);
        checkStatus("reset", 3'b000, 1'b0, 2'd3, 8'd0);
        checkPulses("reset", 1'b0, 1'b0);

        // Ticks and collisions in IDLE are ignored
        colOut = 3'b100;
        frames(2);
        colOut = 3'b000;
        step(1);
        checkStatus("idleIgnore", 3'b000, 1'b0, 2'd3, 8'd0);

        startGame("start1", 3'b000);
        serveToPlay("serve1", 2'd3, 8'd0);

`ifdef PONG_PAUSE_EN
        pause = 1'b1;
        step(3);
        checkStatus("pauseIn", 3'b101, 1'b0, 2'd3, 8'd0);
        pause  = 1'b0;
        colOut = 3'b100;
        step(2);
        colOut = 3'b000;
        frames(3);
        checkStatus("pauseFrozen", 3'b101, 1'b0, 2'd3, 8'd0);
        pause = 1'b1;
        step(3);
        checkStatus("pauseOut", 3'b010, 1'b1, 2'd3, 8'd0);
        pause = 1'b0;
        step(2);
`endif

        // Start during PLAY does nothing
        start = 1'b1;
        step(4);
        checkStatus("startInPlay", 3'b010, 1'b1, 2'd3, 8'd0);
        checkPulses("startInPlay", 1'b0, 1'b0);
        start = 1'b0;
        step(2);

        // Sustained hit code counts once
        colOut = 3'b100;
        step(20);
        check("hitHeld", 32'(score), 32'd1);
        colOut = 3'b000;
        step(2);
        colOut = 3'b100;
        step(2);
        colOut = 3'b000;
        step(1);
        checkStatus("hitTwice", 3'b010, 1'b1, 2'd3, 8'd2);

        // Saturation at all-ones
        for (int i = 0; i < 260; i++) begin
            colOut = 3'b100;
            step(1);
            colOut = 3'b000;
            step(1);
        end
        checkStatus("scoreSat", 3'b010, 1'b1, 2'd3, 8'd255);

        // 100 -> 101 jump: the miss is taken
        colOut = 3'b100;
        step(1);
        colOut = 3'b101;
        step(1);
        checkStatus("miss1", 3'b011, 1'b0, 2'd2, 8'd255);
        step(3);
        colOut = 3'b000;
        missToServe("miss1", 2'd2, 8'd255);
        serveToPlay("serve2", 2'd2, 8'd255);

        colOut = 3'b101;
        step(1);
        colOut = 3'b000;
        checkStatus("miss2", 3'b011, 1'b0, 2'd1, 8'd255);
        missToServe("miss2", 2'd1, 8'd255);
        serveToPlay("serve3", 2'd1, 8'd255);

        colOut = 3'b101;
        step(1);
        colOut = 3'b000;
        checkStatus("over", 3'b100, 1'b0, 2'd0, 8'd255);

        colOut = 3'b100;
        frames(3);
        colOut = 3'b000;
        step(1);
        checkStatus("overHold", 3'b100, 1'b0, 2'd0, 8'd255);

        startGame("start2", 3'b100);
        serveToPlay("serve4", 2'd3, 8'd0);
        colOut = 3'b100;
        step(1);
        colOut = 3'b000;
        check("hitNewGame", 32'(score), 32'd1);

        // Asynchronous reset mid-game
        step(1);
        #2;
        rstN = 1'b0;
        #1;
        checkStatus("midReset", 3'b000, 1'b0, 2'd3, 8'd0);
        checkPulses("midReset", 1'b0, 1'b0);
        step(2);
        rstN = 1'b1;
        step(2);
        checkStatus("afterReset", 3'b000, 1'b0, 2'd3, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
